// File: rtl/pcs_sync_pkg.sv
// pcs_sync_pkg: shared definitions for the 1000BASE-X PCS receive
// synchronization logic.
//   - sync_state_e    : synchronization FSM states
//   - COMMA_P/COMMA_N : 7-bit comma patterns matched on code-group bits a..g
//   - SYNC_LEVEL_NONE : SYNC_LEVEL value reported while not synchronized
package pcs_sync_pkg;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED,
    SYNC_ACQUIRED_A
  } sync_state_e;

  localparam logic [6:0] COMMA_P         = 7'b0011111;
  localparam logic [6:0] COMMA_N         = 7'b1100000;
  localparam logic [2:0] SYNC_LEVEL_NONE = 3'd7;

endpackage

// File: rtl/pcs_comma_detect.sv
// pcs_comma_detect: combinational comma recognizer.
// Ports:
//   cg_hi_i  in  7  code-group bits a..g (PUDI[9:3])
//   comma_o  out 1  1 when the bits match either comma polarity
module pcs_comma_detect
  import pcs_sync_pkg::*;
(
  input  logic [6:0] cg_hi_i,
  output logic       comma_o
);

  assign comma_o = (cg_hi_i == COMMA_P) || (cg_hi_i == COMMA_N);

endmodule

// File: rtl/pcs_sync_fsm_p.sv
// pcs_sync_fsm_p: 1000BASE-X PCS receive code-group synchronization FSM.
// Acquires sync after ACQ_COMMAS even-aligned comma + /D/ pairs, then
// tracks code-group errors through BAD_LEVELS degradation levels with
// good-run recovery.
// Ports:
//   CLK            in  1   clock, rising edge
//   RESET          in  1   asynchronous active-low reset
//   SIGNAL_DETECT  in  1   PMD signal present
//   SIGNAL_CHANGE  in  1   one-cycle pulse on SIGNAL_DETECT change
//   MR_LOOPBACK    in  1   loopback; masks the two signal inputs
//   PUDI           in  10  received code-group, PUDI[9] = bit a
//   PUDI_VALID     in  1   code-group valid with correct disparity
//   PUDI_DATA      in  1   code-group is a /D/
//   CODE_SYNC      out 1   code_sync_status OK
//   RX_EVEN        out 1   parity of the code-group in SUDI
//   SUDI           out 10  PUDI delayed by one clock
//   GOOD_CGS       out 4   good-run counter
//   SYNC_LEVEL     out 3   degradation level, 7 when not synchronized
module pcs_sync_fsm_p
  import pcs_sync_pkg::*;
#(
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS_MAX = 3,
  parameter int BAD_LEVELS   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SIGNAL_DETECT,
  input  logic       SIGNAL_CHANGE,
  input  logic       MR_LOOPBACK,
  input  logic [9:0] PUDI,
  input  logic       PUDI_VALID,
  input  logic       PUDI_DATA,
  output logic       CODE_SYNC,
  output logic       RX_EVEN,
  output logic [9:0] SUDI,
  output logic [3:0] GOOD_CGS,
  output logic [2:0] SYNC_LEVEL
);

  localparam logic [2:0] ACQ_C  = 3'(ACQ_COMMAS);
  localparam logic [2:0] BAD_C  = 3'(BAD_LEVELS);
  localparam logic [3:0] GMAX_C = 4'(GOOD_CGS_MAX);

  sync_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [3:0]  good_q, good_d;
  logic        rx_even_q, rx_even_d;
  logic        code_sync_q, code_sync_d;
  logic [9:0]  sudi_q, sudi_d;

  logic comma, sig_ok, cgbad, isdata, force_los;

  function automatic logic [3:0] good_inc(input logic [3:0] g);
    return (g >= GMAX_C) ? GMAX_C : g + 4'd1;
  endfunction

  pcs_comma_detect u_comma (
    .cg_hi_i (PUDI[9:3]),
    .comma_o (comma)
  );

  assign sig_ok    = MR_LOOPBACK | SIGNAL_DETECT;
  // A comma is only legal in the even slot; one seen while the previous
  // group was even (RX_EVEN=1) is misaligned and counts as bad.
  assign cgbad     = !PUDI_VALID | (comma & rx_even_q);
  assign isdata    = PUDI_VALID & PUDI_DATA;
  assign force_los = !MR_LOOPBACK & (SIGNAL_CHANGE | !SIGNAL_DETECT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    good_d  = good_q;

    if (force_los) begin
      state_d = LOSS_OF_SYNC;
    end else begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (sig_ok && comma) begin
            state_d = COMMA_DETECT;
            cnt_d   = 3'd1;
          end
        end
        COMMA_DETECT: begin
          if (!isdata) begin
            state_d = LOSS_OF_SYNC;
          end else if (cnt_q == ACQ_C) begin
            state_d = SYNC_ACQUIRED;
            lvl_d   = 3'd0;
            good_d  = 4'd0;
          end else begin
            state_d = ACQUIRE_SYNC;
          end
        end
        ACQUIRE_SYNC: begin
          if (cgbad) begin
            state_d = LOSS_OF_SYNC;
          end else if (comma && !rx_even_q) begin
            state_d = COMMA_DETECT;
            cnt_d   = (cnt_q >= ACQ_C) ? ACQ_C : cnt_q + 3'd1;
          end
        end
        SYNC_ACQUIRED, SYNC_ACQUIRED_A: begin
          if (cgbad) begin
            // BAD_C >= 1, so level 0 always degrades to level 1 here.
            if (lvl_q == BAD_C) begin
              state_d = LOSS_OF_SYNC;
            end else begin
              state_d = SYNC_ACQUIRED;
              lvl_d   = lvl_q + 3'd1;
              good_d  = 4'd0;
            end
          end else if (state_q == SYNC_ACQUIRED) begin
            if (lvl_q != 3'd0) begin
              state_d = SYNC_ACQUIRED_A;
              good_d  = 4'd1;
            end
          end else if (good_q == GMAX_C) begin
            state_d = SYNC_ACQUIRED;
            lvl_d   = lvl_q - 3'd1;
            good_d  = 4'd0;
          end else begin
            good_d = good_inc(good_q);
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end

    if (state_d == LOSS_OF_SYNC) begin
      cnt_d  = 3'd0;
      good_d = 4'd0;
    end
    if ((state_d != SYNC_ACQUIRED) && (state_d != SYNC_ACQUIRED_A)) begin
      lvl_d = SYNC_LEVEL_NONE;
    end

    // Entering COMMA_DETECT re-anchors parity on the comma just consumed.
    rx_even_d   = (state_d == COMMA_DETECT) ? 1'b1 : !rx_even_q;
    code_sync_d = (state_d == SYNC_ACQUIRED) || (state_d == SYNC_ACQUIRED_A);
    sudi_d      = PUDI;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= LOSS_OF_SYNC;
      cnt_q       <= 3'd0;
      lvl_q       <= SYNC_LEVEL_NONE;
      good_q      <= 4'd0;
      rx_even_q   <= 1'b0;
      code_sync_q <= 1'b0;
      sudi_q      <= 10'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_q       <= lvl_d;
      good_q      <= good_d;
      rx_even_q   <= rx_even_d;
      code_sync_q <= code_sync_d;
      sudi_q      <= sudi_d;
    end
  end

  assign CODE_SYNC  = code_sync_q;
  assign RX_EVEN    = rx_even_q;
  assign SUDI       = sudi_q;
  assign GOOD_CGS   = good_q;
  assign SYNC_LEVEL = lvl_q;

endmodule

// File: tb/tb_pcs_sync_fsm_p.sv
// tb_pcs_sync_fsm_p: directed scenarios plus randomized traffic for
// pcs_sync_fsm_p, checked cycle by cycle against a behavioural model.
module tb_pcs_sync_fsm_p;

  localparam int ACQ  = 3;
  localparam int GMAX = 3;
  localparam int BAD  = 3;

  localparam logic [9:0] K_P    = 10'b0011111010;
  localparam logic [9:0] K_N    = 10'b1100000101;
  localparam logic [9:0] D16_2  = 10'b1001000101;

  // behavioural model phases
  localparam int PH_LOST   = 0;
  localparam int PH_SEEN   = 1;
  localparam int PH_HUNT   = 2;
  localparam int PH_LOCK   = 3;
  localparam int PH_RECOV  = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SIGNAL_DETECT = 1'b0;
  logic       SIGNAL_CHANGE = 1'b0;
  logic       MR_LOOPBACK = 1'b0;
  logic [9:0] PUDI = 10'd0;
  logic       PUDI_VALID = 1'b0;
  logic       PUDI_DATA = 1'b0;
  logic       CODE_SYNC;
  logic       RX_EVEN;
  logic [9:0] SUDI;
  logic [3:0] GOOD_CGS;
  logic [2:0] SYNC_LEVEL;

  int n_checks = 0;
  int n_errors = 0;

  int         m_phase;
  int         m_commas;
  int         m_k;
  int         m_run;
  bit         m_even;
  logic [9:0] m_sudi;

  logic [9:0] rp;
  logic       rv, rd;
  bit         slot;

  pcs_sync_fsm_p #(
    .ACQ_COMMAS   (ACQ),
    .GOOD_CGS_MAX (GMAX),
    .BAD_LEVELS   (BAD)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .SIGNAL_DETECT (SIGNAL_DETECT),
    .SIGNAL_CHANGE (SIGNAL_CHANGE),
    .MR_LOOPBACK   (MR_LOOPBACK),
    .PUDI          (PUDI),
    .PUDI_VALID    (PUDI_VALID),
    .PUDI_DATA     (PUDI_DATA),
    .CODE_SYNC     (CODE_SYNC),
    .RX_EVEN       (RX_EVEN),
    .SUDI          (SUDI),
    .GOOD_CGS      (GOOD_CGS),
    .SYNC_LEVEL    (SYNC_LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_locked();
    return (m_phase == PH_LOCK) || (m_phase == PH_RECOV);
  endfunction

  task automatic model_reset();
    m_phase  = PH_LOST;
    m_commas = 0;
    m_k      = 0;
    m_run    = 0;
    m_even   = 1'b0;
    m_sudi   = 10'd0;
  endtask

  // One received code-group, evaluated from the inputs currently applied.
  task automatic model_step();
    bit is_comma, bad, data, present;
    int np;
    is_comma = (PUDI[9:3] == 7'b0011111) || (PUDI[9:3] == 7'b1100000);
    bad      = !PUDI_VALID || (is_comma && m_even);
    data     = PUDI_VALID && PUDI_DATA;
    present  = MR_LOOPBACK || SIGNAL_DETECT;
    np       = m_phase;
    if (!MR_LOOPBACK && (SIGNAL_CHANGE || !SIGNAL_DETECT)) begin
      np = PH_LOST;
    end else if (m_phase == PH_LOST) begin
      if (present && is_comma) begin
        np = PH_SEEN;
        m_commas = 1;
      end
    end else if (m_phase == PH_SEEN) begin
      if (!data) np = PH_LOST;
      else if (m_commas == ACQ) begin
        np = PH_LOCK;
        m_k = 0;
        m_run = 0;
      end else np = PH_HUNT;
    end else if (m_phase == PH_HUNT) begin
      if (bad) np = PH_LOST;
      else if (is_comma && !m_even) begin
        np = PH_SEEN;
        m_commas = (m_commas + 1 > ACQ) ? ACQ : m_commas + 1;
      end
    end else begin
      if (bad) begin
        if (m_k == BAD) np = PH_LOST;
        else begin
          np = PH_LOCK;
          m_k++;
          m_run = 0;
        end
      end else if (m_phase == PH_LOCK) begin
        if (m_k > 0) begin
          np = PH_RECOV;
          m_run = 1;
        end
      end else if (m_run == GMAX) begin
        np = PH_LOCK;
        m_k--;
        m_run = 0;
      end else begin
        m_run = (m_run + 1 > GMAX) ? GMAX : m_run + 1;
      end
    end
    if (np == PH_LOST) begin
      m_commas = 0;
      m_run = 0;
    end
    m_even  = (np == PH_SEEN) ? 1'b1 : !m_even;
    m_sudi  = PUDI;
    m_phase = np;
  endtask

  task automatic check_model();
    chk("code_sync", CODE_SYNC, m_locked());
    chk("rx_even", RX_EVEN, m_even);
    chk("sudi", SUDI, m_sudi);
    chk("good_cgs", GOOD_CGS, m_run);
    chk("sync_level", SYNC_LEVEL, m_locked() ? m_k : 7);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_code_sync"}, CODE_SYNC, 0);
    chk({tag, "_rx_even"}, RX_EVEN, 0);
    chk({tag, "_sudi"}, SUDI, 0);
    chk({tag, "_good_cgs"}, GOOD_CGS, 0);
    chk({tag, "_sync_level"}, SYNC_LEVEL, 7);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input logic [9:0] p, input logic v, input logic d);
    PUDI       = p;
    PUDI_VALID = v;
    PUDI_DATA  = d;
    @(posedge CLK);
    model_step();
    #1;
    check_model();
  endtask

  task automatic acquire();
    repeat (ACQ) begin
      cycle(K_P, 1'b1, 1'b0);
      cycle(D16_2, 1'b1, 1'b1);
    end
  endtask

  initial begin
    model_reset();
    #1 RESET = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;

    // Acquisition: three comma/data pairs
    SIGNAL_DETECT = 1'b1;
    for (int i = 0; i < ACQ; i++) begin
      cycle(K_P, 1'b1, 1'b0);
      chk("acq_sudi_k", SUDI, K_P);
      chk("acq_even_k", RX_EVEN, 1);
      cycle(D16_2, 1'b1, 1'b1);
      chk("acq_even_d", RX_EVEN, 0);
      chk("acq_sync", CODE_SYNC, (i == ACQ - 1) ? 1 : 0);
    end
    chk("acq_level", SYNC_LEVEL, 0);

    // Misaligned comma
    cycle(D16_2, 1'b1, 1'b1);
    chk("odd_even_before", RX_EVEN, 1);
    cycle(K_P, 1'b1, 1'b0);
    chk("odd_level", SYNC_LEVEL, 1);
    chk("odd_good", GOOD_CGS, 0);
    chk("odd_sync", CODE_SYNC, 1);

    // Recovery after four good groups
    for (int i = 1; i <= GMAX; i++) begin
      cycle(D16_2, 1'b1, 1'b1);
      chk("rec_good", GOOD_CGS, i);
      chk("rec_level_hold", SYNC_LEVEL, 1);
    end
    cycle(D16_2, 1'b1, 1'b1);
    chk("rec_level", SYNC_LEVEL, 0);
    chk("rec_good_clr", GOOD_CGS, 0);

    // Loss through consecutive invalid groups
    for (int i = 1; i <= BAD; i++) begin
      cycle(D16_2, 1'b0, 1'b0);
      chk("loss_level", SYNC_LEVEL, i);
      chk("loss_sync_hold", CODE_SYNC, 1);
    end
    cycle(D16_2, 1'b0, 1'b0);
    chk("loss_sync", CODE_SYNC, 0);
    chk("loss_level_none", SYNC_LEVEL, 7);

    // SIGNAL_CHANGE while synced
    acquire();
    chk("reacq_sync", CODE_SYNC, 1);
    SIGNAL_CHANGE = 1'b1;
    cycle(D16_2, 1'b1, 1'b1);
    SIGNAL_CHANGE = 1'b0;
    chk("sigchg_sync", CODE_SYNC, 0);
    chk("sigchg_level", SYNC_LEVEL, 7);

    // Same event masked by loopback
    acquire();
    MR_LOOPBACK   = 1'b1;
    SIGNAL_CHANGE = 1'b1;
    SIGNAL_DETECT = 1'b0;
    cycle(D16_2, 1'b1, 1'b1);
    chk("lb_sync", CODE_SYNC, 1);
    chk("lb_level", SYNC_LEVEL, 0);
    SIGNAL_CHANGE = 1'b0;
    SIGNAL_DETECT = 1'b1;
    MR_LOOPBACK   = 1'b0;

    // No signal: commas ignored
    SIGNAL_DETECT = 1'b0;
    acquire();
    chk("nosig_sync", CODE_SYNC, 0);
    chk("nosig_level", SYNC_LEVEL, 7);

    // Asynchronous reset during ACQUIRE_SYNC
    SIGNAL_DETECT = 1'b1;
    cycle(K_P, 1'b1, 1'b0);
    cycle(D16_2, 1'b1, 1'b1);
    #3 RESET = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (ACQ - 1) begin
      cycle(K_P, 1'b1, 1'b0);
      cycle(D16_2, 1'b1, 1'b1);
    end
    chk("midrst_partial", CODE_SYNC, 0);
    cycle(K_N, 1'b1, 1'b0);
    cycle(D16_2, 1'b1, 1'b1);
    chk("midrst_reacq", CODE_SYNC, 1);

    // Randomized traffic
    slot = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      SIGNAL_CHANGE = ($urandom_range(0, 149) == 0);
      if (SIGNAL_DETECT) begin
        if ($urandom_range(0, 299) == 0) SIGNAL_DETECT = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        SIGNAL_DETECT = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) MR_LOOPBACK = !MR_LOOPBACK;
      if (!slot) begin
        rp = $urandom_range(0, 1) ? K_P : K_N;
        rv = 1'b1;
        rd = 1'b0;
      end else begin
        rp = 10'($urandom);
        rv = 1'b1;
        rd = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) rv = 1'b0;
      if ($urandom_range(0, 59) == 0) rp = 10'($urandom);
      if ($urandom_range(0, 79) == 0) rd = !rd;
      if ($urandom_range(0, 59) != 0) slot = !slot;
      cycle(rp, rv, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pcs_sync_fsm_p.md
Name: pcs_sync_fsm_p

Overview:
- Parametrised 1000BASE-X PCS receive synchronization FSM, following the IEEE 802.3 Clause 36 structure (Fig. 36-9).
- Receives one 10-bit code-group per CLK and tags it with even/odd parity. Declares code-group sync after ACQ_COMMAS even-aligned comma+data pairs.
- Tracks code-group errors through BAD_LEVELS degradation levels, with good-run recovery.
- Sits between the deserializer/10b-decoder and the receive state machine.

Parameters:
- ACQ_COMMAS, 3, comma+/D/ pairs needed to reach SYNC_ACQUIRED (1..7).
- GOOD_CGS_MAX, 3, good_cgs value at which one further good code-group climbs one level (1..15).
- BAD_LEVELS, 3, bad-degradation levels tolerated; a cgbad at level BAD_LEVELS goes to LOSS_OF_SYNC (1..7).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SIGNAL_DETECT  in  1  PMD signal present.
- SIGNAL_CHANGE  in  1  one-cycle pulse on any SIGNAL_DETECT change.
- MR_LOOPBACK  in  1  loopback mode; masks SIGNAL_DETECT/SIGNAL_CHANGE.
- PUDI  in  10  received code-group; PUDI[9] = bit 'a'.
- PUDI_VALID  in  1  upstream decoder: code-group is in the 10b table with correct running disparity.
- PUDI_DATA  in  1  upstream decoder: code-group is a /D/ (valid data).
- CODE_SYNC  out  1  1 = code_sync_status OK.
- RX_EVEN  out  1  parity of the code-group in SUDI.
- SUDI  out  10  registered PUDI.
- GOOD_CGS  out  4  good-run counter.
- SYNC_LEVEL  out  3  0 = SYNC_ACQUIRED_1; k = degradation level k; 7 when not synced.

Behaviour:
- Reset (RESET=0, async): state LOSS_OF_SYNC, CODE_SYNC=0, RX_EVEN=0, SUDI=0, GOOD_CGS=0, SYNC_LEVEL=7, comma_cnt=0.
- Derived signals, combinational, current cycle:
  - comma = PUDI[9:3] equals 7'b0011111 or 7'b1100000.
  - sig_ok = MR_LOOPBACK | SIGNAL_DETECT.
  - cgbad = !PUDI_VALID | (comma & RX_EVEN).
  - cggood = !cgbad.
  - isdata = PUDI_VALID & PUDI_DATA.
- Force rule, highest priority: if !MR_LOOPBACK & (SIGNAL_CHANGE | !SIGNAL_DETECT), next state = LOSS_OF_SYNC.
- Destination-state actions, applied at the edge that consumes PUDI (1-cycle latency PUDI->SUDI):
  - SUDI <= PUDI every cycle.
  - RX_EVEN <= 1 when entering COMMA_DETECT; otherwise RX_EVEN <= !RX_EVEN.
  - CODE_SYNC <= 1 iff destination is SYNC_ACQUIRED or SYNC_ACQUIRED_A.
- States and transitions (comma_cnt: 1..ACQ_COMMAS; level k: 0..BAD_LEVELS):
  - LOSS_OF_SYNC:
    - sig_ok & comma -> COMMA_DETECT, comma_cnt=1.
    - otherwise stay.
  - COMMA_DETECT:
    - !isdata -> LOSS_OF_SYNC.
    - isdata & comma_cnt==ACQ_COMMAS -> SYNC_ACQUIRED, k=0.
    - isdata otherwise -> ACQUIRE_SYNC.
  - ACQUIRE_SYNC:
    - cgbad -> LOSS_OF_SYNC.
    - comma & !RX_EVEN -> COMMA_DETECT, comma_cnt+1.
    - otherwise stay.
  - SYNC_ACQUIRED, k=0: cggood -> stay; cgbad -> SYNC_ACQUIRED, k=1, GOOD_CGS=0.
  - SYNC_ACQUIRED, k>=1: cggood -> SYNC_ACQUIRED_A, k, GOOD_CGS=1.
  - SYNC_ACQUIRED_A, k:
    - cggood & GOOD_CGS==GOOD_CGS_MAX -> SYNC_ACQUIRED, k-1, GOOD_CGS=0.
    - cggood otherwise -> stay, GOOD_CGS+1.
  - Any cgbad at level k>=1 (either state): k==BAD_LEVELS -> LOSS_OF_SYNC; else SYNC_ACQUIRED, k+1, GOOD_CGS=0.
- Recovery: a level is recovered after GOOD_CGS_MAX+1 consecutive cggood.
- GOOD_CGS saturates at GOOD_CGS_MAX and clears on entry to LOSS_OF_SYNC.
- comma_cnt never exceeds ACQ_COMMAS.
- Entering LOSS_OF_SYNC: SYNC_LEVEL=7, comma_cnt=0.

Decomposition:
- Package pcs_sync_pkg:
  - state enum (LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED, SYNC_ACQUIRED_A);
  - COMMA_P=7'b0011111, COMMA_N=7'b1100000;
  - SYNC_LEVEL_NONE=3'd7.
- Sub-module pcs_comma_detect: combinational comma match on PUDI[9:3], reused by the future alignment block.

Test Plan:
- Acquire: SIGNAL_DETECT=1; 3x {K28.5 10'b0011111010, D16.2 10'b1001000101}, all valid -> CODE_SYNC=1 after the 6th edge, SYNC_LEVEL=0, RX_EVEN alternates, SUDI lags PUDI by 1 cycle.
- Odd comma: in SYNC_ACQUIRED, drive a comma when RX_EVEN=1 -> SYNC_LEVEL=1, GOOD_CGS=0, CODE_SYNC stays 1.
- Recovery: at level 1, drive 4 valid data groups -> GOOD_CGS 1,2,3, then SYNC_LEVEL=0, GOOD_CGS=0.
- Loss: 4 consecutive PUDI_VALID=0 -> levels 1,2,3, then LOSS_OF_SYNC, CODE_SYNC=0, SYNC_LEVEL=7.
- Signal events:
  - SIGNAL_CHANGE pulse while synced, MR_LOOPBACK=0 -> LOSS_OF_SYNC next edge.
  - Same pulse with MR_LOOPBACK=1 -> no change.
  - SIGNAL_DETECT=0 with commas -> stays in LOSS_OF_SYNC.
- Reset mid-acquire: RESET low asynchronously in ACQUIRE_SYNC -> all outputs at reset values immediately; re-acquisition after release needs the full 3 pairs.
